// File: rtl/csa_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
// CSA_SAT_EN selects saturating results in csa_pipe_adder.
package csa_pkg;

  localparam int CSA_WIDTH  = 32;
  localparam int CSA_GROUP  = 4;
  localparam int CSA_STAGES = 2;
  localparam int CSA_MAXW   = 256;

  function automatic int csa_ngrp(
    input int w,
    input int g
  );
    return w / g;
  endfunction

  function automatic int csa_gps(
    input int w,
    input int g,
    input int s
  );
    return csa_ngrp(w, g) / s;
  endfunction

  function automatic logic csa_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  function automatic logic [CSA_MAXW-1:0] csa_sat_max(
    input int w
  );
    logic [CSA_MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < CSA_MAXW; i++) begin
      if (i < w - 1) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [CSA_MAXW-1:0] csa_sat_min(
    input int w
  );
    logic [CSA_MAXW-1:0] m;
    m = '0;
    for (int i = 0; i < CSA_MAXW; i++) begin
      if (i == w - 1) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/csa_pipe_adder_group.sv
// One carry-select group: two ripple sums (carry 0 and 1) and a select.
// Used by csa_pipe_adder; behaviour is independent of CSA_SAT_EN.
module csa_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a_i,
  input  logic [GROUP-1:0] b_i,
  input  logic             c_i,
  output logic [GROUP-1:0] s_o,
  output logic             c_o
);

  logic [GROUP-1:0] s0;
  logic [GROUP-1:0] s1;
  logic             k0;
  logic             k1;

  always_comb begin
    s0 = '0;
    s1 = '0;
    k0 = 1'b0;
    k1 = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      s0[i] = a_i[i] ^ b_i[i] ^ k0;
      k0    = (a_i[i] & b_i[i]) |
              (k0 & (a_i[i] ^ b_i[i]));
      s1[i] = a_i[i] ^ b_i[i] ^ k1;
      k1    = (a_i[i] & b_i[i]) |
              (k1 & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o = c_i ? s1 : s0;
  assign c_o = c_i ? k1 : k0;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder with valid/ready flow control.
// Define CSA_SAT_EN for saturating signed results.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int GROUP  = CSA_GROUP,
  parameter int STAGES = CSA_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GPS  = csa_gps(WIDTH, GROUP, STAGES);
  localparam int SL   = GPS * GROUP;
  localparam int LAST = STAGES - 1;

  logic [STAGES-1:0]            valid_q;
  logic [STAGES-1:0]            en;
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0]            c_d;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] src_a;
  logic [STAGES-1:0][WIDTH-1:0] src_b;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] sum_d;
  logic [STAGES-1:0][WIDTH-1:0] sum_q;
  logic [WIDTH-1:0]             fin_d;
  logic                         ovf_d;
  logic                         ovf_q;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SL-1:0] gs;

      // A stage can load if any stage at or after it holds a bubble
      assign en[k] = out_ready | ~(&valid_q[LAST:k]);

      if (k == 0) begin : g_head
        assign src_v[k] = in_valid;
        assign src_a[k] = a;
        assign src_b[k] = b;
        assign src_c[k] = cin;
      end else begin : g_link
        assign src_v[k] = valid_q[k-1];
        assign src_a[k] = a_q[k-1];
        assign src_b[k] = b_q[k-1];
        assign src_c[k] = c_q[k-1];
        assign sum_d[k][k*SL-1:0] =
          sum_q[k-1][k*SL-1:0];
      end

      if (k < LAST) begin : g_pad
        assign sum_d[k][WIDTH-1:(k+1)*SL] = '0;
      end

      for (genvar g = 0; g < GPS; g++) begin : g_grp
        localparam int LO = k * SL + g * GROUP;
        logic ci;
        logic co;

        if (g == 0) begin : g_c0
          assign ci = src_c[k];
        end else begin : g_cn
          assign ci = g_grp[g-1].co;
        end

        csa_group #(
          .GROUP(GROUP)
        ) u_grp (
          .a_i(src_a[k][LO +: GROUP]),
          .b_i(src_b[k][LO +: GROUP]),
          .c_i(ci),
          .s_o(gs[g*GROUP +: GROUP]),
          .c_o(co)
        );
      end

      assign sum_d[k][k*SL +: SL] = gs;
      assign c_d[k] = g_grp[GPS-1].co;
    end
  endgenerate

  assign ovf_d = csa_ovf(src_a[LAST][WIDTH-1],
                         src_b[LAST][WIDTH-1],
                         sum_d[LAST][WIDTH-1]);

`ifdef CSA_SAT_EN
  localparam logic [CSA_MAXW-1:0] SMAX_W =
    csa_sat_max(WIDTH);
  localparam logic [CSA_MAXW-1:0] SMIN_W =
    csa_sat_min(WIDTH);
  localparam logic [WIDTH-1:0] SMAX =
    SMAX_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SMIN =
    SMIN_W[WIDTH-1:0];

  always_comb begin
    fin_d = sum_d[LAST];
    if (ovf_d) begin
      fin_d = src_a[LAST][WIDTH-1] ? SMIN : SMAX;
    end
  end
`else
  assign fin_d = sum_d[LAST];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      c_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          valid_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            c_q[k]   <= c_d[k];
            sum_q[k] <= (k == LAST) ? fin_d
                                    : sum_d[k];
          end
        end
      end
      if (en[LAST] && src_v[LAST]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = valid_q[LAST];
  assign sum       = sum_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

  // Already-resolved operand bits and unresolved sum bits go nowhere
  logic unused_bits;
  assign unused_bits = ^{a_q, b_q, src_a, src_b, sum_q};

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Randomised self-checking bench for csa_pipe_adder (WIDTH=32, GROUP=4).
// Expected results follow CSA_SAT_EN when it is defined.
module tb_csa_pipe_adder;

  localparam int W  = 32;
  localparam int ST = 2;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
    bit           lat;
  } exp_t;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  exp_t         q[$];
  exp_t         e_in;
  exp_t         e_out;
  int           n_chk = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           n_out = 0;
  bit           free_run = 1'b0;
  bit           stall_prev = 1'b0;
  logic [W-1:0] held_sum = '0;
  logic [W-1:0] last_sum = '0;
  logic         last_c = 1'b0;
  logic         last_o = 1'b0;

  csa_pipe_adder #(
    .WIDTH(W),
    .GROUP(4),
    .STAGES(ST)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .cin(cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .cout(cout),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x,
                                 input logic [W-1:0] y,
                                 input logic c);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
`ifdef CSA_SAT_EN
    if (e.o) begin
      e.s = x[W-1] ? {1'b1, {(W-1){1'b0}}}
                   : {1'b0, {(W-1){1'b1}}};
    end
`endif
    e.cyc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Inputs and out_ready change just after posedge; everything is
  // observed at negedge, where it is stable for the coming edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      e_in     = model(a, b, cin);
      e_in.cyc = cyc;
      e_in.lat = free_run;
      q.push_back(e_in);
    end
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) chk("hold_sum", sum, held_sum);
      stall_prev = out_valid && !out_ready;
      held_sum   = sum;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", out_valid, 1'b0);
        end else begin
          e_out = q.pop_front();
          chk("sum", sum, e_out.s);
          chk("cout", cout, e_out.c);
          chk("ovf", ovf, e_out.o);
          if (e_out.lat) chk("latency", cyc - e_out.cyc, ST);
          last_sum = sum;
          last_c   = cout;
          last_o   = ovf;
          n_out++;
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input logic c);
    int n;
    n        = 0;
    in_valid = 1'b1;
    a        = x;
    b        = y;
    cin      = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int c0;
    int seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    free_run  = 1'b1;

    send(32'hFFFF_FFFF, 32'h0, 1'b1);
    drain();
    chk("t1_sum", last_sum, 32'h0);
    chk("t1_cout", last_c, 1'b1);
    chk("t1_ovf", last_o, 1'b0);

    send(32'h7FFF_FFFF, 32'h1, 1'b0);
    drain();
`ifdef CSA_SAT_EN
    chk("t2_sum", last_sum, 32'h7FFF_FFFF);
`else
    chk("t2_sum", last_sum, 32'h8000_0000);
`endif
    chk("t2_cout", last_c, 1'b0);
    chk("t2_ovf", last_o, 1'b1);

    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();
`ifdef CSA_SAT_EN
    chk("t6_sum", last_sum, 32'h8000_0000);
`else
    chk("t6_sum", last_sum, 32'h0);
`endif
    chk("t6_cout", last_c, 1'b1);
    chk("t6_ovf", last_o, 1'b1);

    n0 = n_out;
    c0 = cyc;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = (i % 10 == 0) ? ~ra : $urandom;
      send(ra, rb, 1'($urandom_range(0, 1)));
    end
    chk("b2b_rate", cyc - c0, 100);
    drain();
    chk("b2b_count", n_out - n0, 100);

    free_run  = 1'b0;
    out_ready = 1'b0;
    n0        = n_out;
    send($urandom, $urandom, 1'b0);
    send($urandom, $urandom, 1'b1);
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    @(posedge clk);
    #1;
    fork
      send(32'h7FFF_0000, 32'h7FFF_0000, 1'b1);
      begin
        repeat (5) @(posedge clk);
        chk("bp_no_emit", n_out - n0, 0);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 3);

    out_ready = 1'b0;
    send($urandom, $urandom, 1'b0);
    send($urandom, $urandom, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_out_valid", out_valid, 1'b0);
    chk("mr_sum", sum, '0);
    q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mr_no_stale", seen, 0);
    @(posedge clk);
    #1;

    free_run = 1'b1;
    n0       = n_out;
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'b1);
    drain();
    chk("post_rst_count", n_out - n0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
